// File: rtl/vmx_array_ctrl.sv
// Job sequencer for a linear vmx PE chain: streams weights with countdown load
// tokens, then input vectors, then waits for the tail sums to drain out.
module vmx_array_ctrl #(
  parameter int NUM_PE         = 8,
  parameter int VECTOR_BITLEN  = 16,
  parameter int PRODUCT_BITLEN = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cfg_simd_mode,
  input  logic [15:0]               cfg_num_vec,
  output logic                      busy,
  output logic                      done,
  input  logic [VECTOR_BITLEN-1:0]  w_data,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [VECTOR_BITLEN-1:0]  x_data,
  input  logic                      x_valid,
  output logic                      x_ready,
  output logic                      arr_simd_mode,
  output logic [7:0]                arr_load_ctrl,
  output logic [VECTOR_BITLEN-1:0]  arr_data,
  output logic [PRODUCT_BITLEN-1:0] arr_sum_in,
  input  logic [PRODUCT_BITLEN-1:0] arr_sum_out,
  output logic [PRODUCT_BITLEN-1:0] res_data,
  output logic                      res_valid
);
  localparam int             WCW      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [7:0]     TOK_IDLE = 8'h7F;
  localparam logic [7:0]     TOK_TOP  = 8'(128 + NUM_PE - 1);
  localparam logic [WCW-1:0] W_LAST   = WCW'(NUM_PE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN} state_t;

  state_t                    r_state;
  logic [WCW-1:0]            r_wcnt;
  logic [15:0]               r_vcnt;
  logic [NUM_PE:0]           r_vld_pipe;
  logic                      r_busy, r_done, r_w_ready, r_x_ready, r_simd, r_res_valid;
  logic [7:0]                r_lc;
  logic [VECTOR_BITLEN-1:0]  r_data;
  logic [PRODUCT_BITLEN-1:0] r_res_data;
  logic                      w_w_hs, w_x_hs;

  assign w_w_hs = w_valid && r_w_ready;
  assign w_x_hs = x_valid && r_x_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_vcnt      <= '0;
      r_vld_pipe  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_ready   <= 1'b0;
      r_x_ready   <= 1'b0;
      r_simd      <= 1'b0;
      r_lc        <= TOK_IDLE;
      r_data      <= '0;
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else begin
      // Array sees the idle token and zero data unless a handshake fires.
      r_done      <= 1'b0;
      r_lc        <= TOK_IDLE;
      r_data      <= '0;
      r_vld_pipe  <= {r_vld_pipe[NUM_PE-1:0], w_x_hs};
      r_res_valid <= r_vld_pipe[NUM_PE];
      if (r_vld_pipe[NUM_PE]) r_res_data <= arr_sum_out;
      case (r_state)
        S_IDLE: if (start) begin
          r_state   <= S_LOAD;
          r_busy    <= 1'b1;
          r_w_ready <= 1'b1;
          r_simd    <= cfg_simd_mode;
          r_vcnt    <= cfg_num_vec;
          r_wcnt    <= '0;
        end
        S_LOAD: if (w_w_hs) begin
          // First weight gets the largest countdown so it travels to the last PE.
          r_data <= w_data;
          r_lc   <= TOK_TOP - 8'(r_wcnt);
          r_wcnt <= r_wcnt + WCW'(1);
          if (r_wcnt == W_LAST) begin
            r_w_ready <= 1'b0;
            r_wcnt    <= '0;
            if (r_vcnt == '0) begin
              r_state <= S_DRAIN;
            end else begin
              r_state   <= S_COMPUTE;
              r_x_ready <= 1'b1;
            end
          end
        end
        S_COMPUTE: if (w_x_hs) begin
          r_data <= x_data;
          r_vcnt <= r_vcnt - 16'd1;
          if (r_vcnt == 16'd1) begin
            r_x_ready <= 1'b0;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: if (r_vld_pipe == '0) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign w_ready       = r_w_ready;
  assign x_ready       = r_x_ready;
  assign arr_simd_mode = r_simd;
  assign arr_load_ctrl = r_lc;
  assign arr_data      = r_data;
  assign arr_sum_in    = '0;
  assign res_data      = r_res_data;
  assign res_valid     = r_res_valid;
endmodule

// File: tb/tb_vmx_array_ctrl.sv
// Bench for vmx_array_ctrl: job table plus random jobs scored against a
// cycle-accurate expectation model, plus a mid-job asynchronous reset.
module tb_vmx_array_ctrl;
  localparam int NPE = 4;
  localparam int VB  = 16;
  localparam int PB  = 32;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_simd_mode = 1'b0;
  logic [15:0]   cfg_num_vec = '0;
  logic          busy, done, w_ready, x_ready, arr_simd_mode, res_valid;
  logic [VB-1:0] w_data = '0, x_data = '0, arr_data;
  logic          w_valid = 1'b0, x_valid = 1'b0;
  logic [7:0]    arr_load_ctrl;
  logic [PB-1:0] arr_sum_in, arr_sum_out, res_data;

  always #5 clk = ~clk;

  vmx_array_ctrl #(.NUM_PE(NPE), .VECTOR_BITLEN(VB), .PRODUCT_BITLEN(PB)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_simd_mode(cfg_simd_mode),
    .cfg_num_vec(cfg_num_vec), .busy(busy), .done(done),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .arr_simd_mode(arr_simd_mode), .arr_load_ctrl(arr_load_ctrl),
    .arr_data(arr_data), .arr_sum_in(arr_sum_in), .arr_sum_out(arr_sum_out),
    .res_data(res_data), .res_valid(res_valid)
  );

  function automatic logic [PB-1:0] pe_sum(input logic [VB-1:0] d);
    return {~d, d};
  endfunction

  // Stand-in PE chain: NPE cycles of latency from arr_data to arr_sum_out.
  logic [VB-1:0] chain [NPE];
  always @(posedge clk) begin
    chain[0] <= arr_data;
    for (int i = 1; i < NPE; i++) chain[i] <= chain[i-1];
  end
  assign arr_sum_out = pe_sum(chain[NPE-1]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {
    bit simd;
    int nvec;
    int wmode;   // 0 back-to-back, 1 toggling, 2 random
    int xmode;
    bit inj;     // pulse a conflicting start mid-job
    int exp_res;
  } job_t;

  function automatic bit pick(input int mode, inout bit tgl);
    if (mode == 0) return 1'b1;
    if (mode == 1) begin tgl = ~tgl; return tgl; end
    return 1'($urandom_range(0, 1));
  endfunction

  // Entered and left on a negedge with the DUT idle.
  task automatic run_job(input job_t j);
    int         wk = 0, vk = 0, n_res = 0, done_due = -1;
    bit         fin = 0, inj_done = 0, wt = 0, xt = 0;
    logic [7:0] exp_lc = 8'h7F;
    logic [VB-1:0] exp_d = '0;
    int         due_q[$];
    logic [PB-1:0] val_q[$];
    cfg_simd_mode = j.simd;
    cfg_num_vec   = 16'(j.nvec);
    start         = 1'b1;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy", busy, (done_due < 0) || (cyc < done_due));
      chk("done", done, cyc == done_due);
      chk("w_ready", w_ready, wk < NPE);
      chk("x_ready", x_ready, (wk == NPE) && (vk < j.nvec));
      chk("arr_load_ctrl", arr_load_ctrl, exp_lc);
      chk("arr_data", arr_data, exp_d);
      chk("arr_simd_mode", arr_simd_mode, j.simd);
      chk("arr_sum_in", arr_sum_in, 0);
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        chk("res_valid", res_valid, 1);
        chk("res_data", res_data, val_q[0]);
        void'(due_q.pop_front());
        void'(val_q.pop_front());
        n_res++;
      end else begin
        chk("res_valid", res_valid, 0);
      end
      if (cyc == done_due) begin
        fin = 1;
      end else begin
        exp_lc  = 8'h7F;
        exp_d   = '0;
        w_data  = 16'($urandom);
        x_data  = 16'($urandom);
        w_valid = 1'($urandom_range(0, 1));
        x_valid = 1'($urandom_range(0, 1));
        if (wk < NPE) begin
          w_valid = pick(j.wmode, wt);
          if (w_valid) begin
            exp_lc = 8'(8'h80 + NPE - 1 - wk);
            exp_d  = w_data;
            wk++;
            if (wk == NPE && j.nvec == 0) done_due = cyc + 2;
          end
        end else if (vk < j.nvec) begin
          x_valid = pick(j.xmode, xt);
          if (x_valid) begin
            exp_d = x_data;
            vk++;
            due_q.push_back(cyc + 1 + NPE + 1);
            val_q.push_back(pe_sum(x_data));
            if (vk == j.nvec) done_due = cyc + 1 + NPE + 2;
          end
          if (j.inj && vk == 1 && !inj_done) begin
            start = 1'b1; cfg_simd_mode = ~j.simd; cfg_num_vec = 16'd9; inj_done = 1;
          end
        end
      end
    end
    if (!fin) chk("job_timeout", 0, 1);
    w_valid = 1'b0;
    x_valid = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("res_count", n_res, j.exp_res);
  endtask

  job_t jobs [6];
  int   n_dn;

  initial begin
    jobs[0] = '{simd: 0, nvec: 3, wmode: 0, xmode: 0, inj: 0, exp_res: 3};
    jobs[1] = '{simd: 0, nvec: 3, wmode: 1, xmode: 1, inj: 0, exp_res: 3};
    jobs[2] = '{simd: 0, nvec: 0, wmode: 0, xmode: 0, inj: 0, exp_res: 0};
    jobs[3] = '{simd: 0, nvec: 4, wmode: 2, xmode: 0, inj: 1, exp_res: 4};
    jobs[4] = '{simd: 1, nvec: 2, wmode: 0, xmode: 2, inj: 0, exp_res: 2};
    jobs[5] = '{simd: 1, nvec: 1, wmode: 1, xmode: 0, inj: 1, exp_res: 1};

    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_simd", arr_simd_mode, 0);
    chk("rst_load_ctrl", arr_load_ctrl, 8'h7F);
    chk("rst_arr_data", arr_data, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_sum_in", arr_sum_in, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Asynchronous reset in the middle of COMPUTE.
    cfg_simd_mode = 1'b1; cfg_num_vec = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; w_valid = 1'b1; w_data = 16'h1234;
    repeat (NPE) @(negedge clk);
    w_valid = 1'b0; x_valid = 1'b1; x_data = 16'h0BEE;
    repeat (2) @(negedge clk);
    x_valid = 1'b0;
    chk("pre_rst_x_ready", x_ready, 1);
    chk("pre_rst_simd", arr_simd_mode, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_load_ctrl", arr_load_ctrl, 8'h7F);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_x_ready", x_ready, 0);
    chk("arst_arr_data", arr_data, 0);
    chk("arst_simd", arr_simd_mode, 0);
    @(negedge clk);
    rst = 1'b0;
    n_dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || res_valid) n_dn++;
    end
    chk("post_rst_quiet", n_dn, 0);
    run_job('{simd: 1, nvec: 3, wmode: 0, xmode: 0, inj: 0, exp_res: 3});

    for (int r = 0; r < 15; r++) begin
      job_t j;
      j.simd    = 1'($urandom_range(0, 1));
      j.nvec    = int'($urandom_range(0, 8));
      j.wmode   = int'($urandom_range(0, 2));
      j.xmode   = int'($urandom_range(0, 2));
      j.inj     = 1'($urandom_range(0, 1));
      j.exp_res = j.nvec;
      run_job(j);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
